// File: rtl/vga_pixel_gen.sv
// Two-stage RGB222 test-pattern generator fed by the raster scan, with delay-matched syncs.
// Optional build macro PIXEL_GEN_BORDER_EN adds a 1-pixel white border around the visible area.
module vga_pixel_gen #(
    parameter int X_BITS     = 11,
    parameter int Y_BITS     = 10,
    parameter int FRAME_BITS = 8,
    parameter int X_ACT      = 640,
    parameter int Y_ACT      = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [X_BITS-1:0]     x,
    input  logic [Y_BITS-1:0]     y,
    input  logic                  active_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic [1:0]            mode,
    output logic [5:0]            rgb,
    output logic                  active_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic [FRAME_BITS-1:0] frame
);

    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_SCROLL  = 2'd2,
        MODE_XOR     = 2'd3
    } mode_e;

    // Frame-level state
    mode_e                 mode_q, mode_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  vsync_prev_q, vsync_prev_d;

    // Stage 1
    logic [5:0] pat_s1_q, pat_s1_d;
    logic       active_s1_q, hsync_s1_q, vsync_s1_q;

    // Stage 2
    logic [5:0] rgb_q, rgb_d;
    logic       active_s2_q, hsync_s2_q, vsync_s2_q;

    logic       vsync_rise;
    logic [5:0] pat_mode;

    assign vsync_rise = vsync_in & ~vsync_prev_q;

    // Frame counter and mode latch advance together on each vsync rising edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        vsync_prev_d = vsync_in;
        frame_d      = frame_q;
        mode_d       = mode_q;
        if (vsync_rise) begin
            frame_d = frame_q + 1'b1;
            mode_d  = mode_e'(mode);
        end
    end

    // Pattern uses the mode and frame held this cycle, not the ones being latched.
    always_comb begin
        pat_mode = 6'h00;
        case (mode_q)
            MODE_BARS:    pat_mode = {x[8:6], y[8:6]};
            MODE_CHECKER: pat_mode = (x[5] ^ y[5]) ? 6'h3F : 6'h00;
            MODE_SCROLL:  pat_mode = 6'(x[7:2] + frame_q);
            MODE_XOR:     pat_mode = x[7:2] ^ y[7:2];
            default:      pat_mode = 6'h00;
        endcase
    end

`ifdef PIXEL_GEN_BORDER_EN
    logic on_border;

    assign on_border = (x == X_BITS'(0)) || (x == X_BITS'(X_ACT - 1)) ||
                       (y == Y_BITS'(0)) || (y == Y_BITS'(Y_ACT - 1));

    always_comb begin
        pat_s1_d = pat_mode;
        if (active_in && on_border) begin
            pat_s1_d = 6'h3F;
        end
    end
`else
    logic unused_border_inputs;

    assign unused_border_inputs = ^{x[X_BITS-1:9], y[Y_BITS-1:9], X_ACT[0], Y_ACT[0]};

    always_comb begin
        pat_s1_d = pat_mode;
    end
`endif

    always_comb begin
        rgb_d = active_s1_q ? pat_s1_q : 6'h00;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= MODE_BARS;
            frame_q      <= '0;
            vsync_prev_q <= 1'b0;
            pat_s1_q     <= 6'h00;
            active_s1_q  <= 1'b0;
            hsync_s1_q   <= 1'b0;
            vsync_s1_q   <= 1'b0;
            rgb_q        <= 6'h00;
            active_s2_q  <= 1'b0;
            hsync_s2_q   <= 1'b0;
            vsync_s2_q   <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            frame_q      <= frame_d;
            vsync_prev_q <= vsync_prev_d;
            pat_s1_q     <= pat_s1_d;
            active_s1_q  <= active_in;
            hsync_s1_q   <= hsync_in;
            vsync_s1_q   <= vsync_in;
            rgb_q        <= rgb_d;
            active_s2_q  <= active_s1_q;
            hsync_s2_q   <= hsync_s1_q;
            vsync_s2_q   <= vsync_s1_q;
        end
    end

    assign rgb        = rgb_q;
    assign active_out = active_s2_q;
    assign hsync_out  = hsync_s2_q;
    assign vsync_out  = vsync_s2_q;
    assign frame      = frame_q;

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Directed self-checking bench for vga_pixel_gen; a second instance with FRAME_BITS=2 checks counter wrap.
module tb_vga_pixel_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] x = '0;
    logic [9:0]  y = '0;
    logic        active_in = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [1:0]  mode = 2'd0;

    logic [5:0]  rgb, rgb_w2;
    logic        active_out, hsync_out, vsync_out;
    logic        active_out_w2, hsync_out_w2, vsync_out_w2;
    logic [7:0]  frame;
    logic [1:0]  frame_w2;

    int tests = 0;
    int fails = 0;

    vga_pixel_gen u_dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .mode(mode),
        .rgb(rgb), .active_out(active_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .frame(frame)
    );

    vga_pixel_gen #(.FRAME_BITS(2)) u_dut_w2 (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .mode(mode),
        .rgb(rgb_w2), .active_out(active_out_w2), .hsync_out(hsync_out_w2), .vsync_out(vsync_out_w2),
        .frame(frame_w2)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge; inputs are changed at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        active_in = 1'b0;
        hsync_in  = 1'b0;
        vsync_in  = 1'b0;
        x         = '0;
        y         = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic vsync_pulse(input logic [1:0] m);
        mode     = m;
        vsync_in = 1'b1;
        step();
        vsync_in = 1'b0;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if ({rgb, active_out, hsync_out, vsync_out, frame} !== 17'h0) begin
                $display("FAIL reset_state cycle %0d: rgb=%h act=%b hs=%b vs=%b frame=%0d, expected all 0",
                         i, rgb, active_out, hsync_out, vsync_out, frame);
                fails++;
            end
        end
        // vsync already high in the first cycle after reset is an edge
        vsync_in = 1'b1;
        step();
        reset = 1'b0;
        step();
        tests++;
        if (frame !== 8'd1) begin
            $display("FAIL vsync_high_after_reset: frame=%0d expected 1", frame);
            fails++;
        end
        step();
        step();
        tests++;
        if (frame !== 8'd1) begin
            $display("FAIL vsync_held_no_recount: frame=%0d expected 1", frame);
            fails++;
        end
        vsync_in = 1'b0;
        step();
    endtask

    task automatic test_checker();
        do_reset();
        vsync_pulse(2'd1);
        active_in = 1'b1;
        x = 11'd32;
        y = 10'd0;
        step();
        step();
        tests++;
        if (rgb !== 6'h3F) begin
            $display("FAIL checker_32_0: rgb=%h expected 3f", rgb);
            fails++;
        end
        x = 11'd32;
        y = 10'd32;
        step();
        step();
        tests++;
        if (rgb !== 6'h00) begin
            $display("FAIL checker_32_32: rgb=%h expected 00", rgb);
            fails++;
        end
    endtask

    task automatic test_blank_hsync();
        idle_inputs();
        vsync_pulse(2'd3);
        active_in = 1'b0;
        x = 11'd5;
        y = 10'd200;
        hsync_in = 1'b1;
        step();
        tests++;
        if (hsync_out !== 1'b0) begin
            $display("FAIL hsync_early: hsync_out=%b expected 0", hsync_out);
            fails++;
        end
        hsync_in = 1'b0;
        step();
        tests++;
        if (hsync_out !== 1'b1 || rgb !== 6'h00) begin
            $display("FAIL hsync_pulse_blank: hsync_out=%b rgb=%h expected 1 and 00", hsync_out, rgb);
            fails++;
        end
        step();
        tests++;
        if (hsync_out !== 1'b0) begin
            $display("FAIL hsync_width: hsync_out=%b expected 0", hsync_out);
            fails++;
        end
        // xor pattern while visible: 84[7:2]=010101 ^ 40[7:2]=001010
        active_in = 1'b1;
        x = 11'd84;
        y = 10'd40;
        step();
        step();
        tests++;
        if (rgb !== 6'h1F || active_out !== 1'b1) begin
            $display("FAIL xor_84_40: rgb=%h act=%b expected 1f and 1", rgb, active_out);
            fails++;
        end
    endtask

    task automatic test_frame_count();
        do_reset();
        for (int r = 0; r < 3; r++) begin
            vsync_in = 1'b1;
            step();
            if (r == 0) begin
                tests++;
                if (frame !== 8'd1 || vsync_out !== 1'b0) begin
                    $display("FAIL vsync_first_edge: frame=%0d vsync_out=%b expected 1 and 0", frame, vsync_out);
                    fails++;
                end
                step();
                tests++;
                if (vsync_out !== 1'b1) begin
                    $display("FAIL vsync_delay: vsync_out=%b expected 1", vsync_out);
                    fails++;
                end
                repeat (8) step();
            end else begin
                repeat (9) step();
            end
            vsync_in = 1'b0;
            repeat (10) step();
        end
        tests++;
        if (frame !== 8'd3 || frame_w2 !== 2'd3) begin
            $display("FAIL frame_three_edges: frame=%0d frame_w2=%0d expected 3 and 3", frame, frame_w2);
            fails++;
        end
        for (int r = 0; r < 2; r++) begin
            vsync_in = 1'b1;
            repeat (10) step();
            vsync_in = 1'b0;
            repeat (10) step();
        end
        tests++;
        if (frame !== 8'd5 || frame_w2 !== 2'd1) begin
            $display("FAIL frame_wrap: frame=%0d frame_w2=%0d expected 5 and 1", frame, frame_w2);
            fails++;
        end
    endtask

    task automatic test_mode_latch();
        do_reset();
        for (int r = 0; r < 3; r++) vsync_pulse(2'd0);
        mode = 2'd2;
        active_in = 1'b1;
        x = 11'd128;
        y = 10'd64;
        step();
        step();
        tests++;
        if (rgb !== 6'h11) begin
            $display("FAIL mode_held_midframe: rgb=%h expected 11", rgb);
            fails++;
        end
        active_in = 1'b0;
        vsync_in = 1'b1;
        step();
        vsync_in = 1'b0;
        active_in = 1'b1;
        x = 11'd8;
        y = 10'd50;
        step();
        step();
        tests++;
        if (rgb !== 6'h06 || frame !== 8'd4) begin
            $display("FAIL scroll_after_edge: rgb=%h frame=%0d expected 06 and 4", rgb, frame);
            fails++;
        end
    endtask

    // Scroll mode at frame 4, one new pixel every cycle.
    task automatic test_back_to_back();
        logic [10:0] xs[8];
        logic        acts[8];
        logic [5:0]  exps[8];
        xs   = '{11'd4, 11'd40, 11'd100, 11'd128, 11'd200, 11'd252, 11'd252, 11'd16};
        acts = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exps = '{6'h05, 6'h0E, 6'h1D, 6'h24, 6'h36, 6'h03, 6'h00, 6'h08};
        y = 10'd50;
        for (int c = 0; c <= 8; c++) begin
            if (c < 8) begin
                x = xs[c];
                active_in = acts[c];
            end else begin
                active_in = 1'b0;
            end
            step();
            if (c >= 1) begin
                tests++;
                if (rgb !== exps[c-1] || active_out !== acts[c-1]) begin
                    $display("FAIL b2b_pixel_%0d: rgb=%h act=%b expected %h and %b",
                             c - 1, rgb, active_out, exps[c-1], acts[c-1]);
                    fails++;
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        active_in = 1'b1;
        x = 11'd128;
        y = 10'd64;
        step();
        reset = 1'b1;
        step();
        tests++;
        if ({rgb, active_out, hsync_out, vsync_out, frame} !== 17'h0) begin
            $display("FAIL midframe_reset_clear: rgb=%h act=%b frame=%0d expected 0", rgb, active_out, frame);
            fails++;
        end
        reset = 1'b0;
        step();
        tests++;
        if (rgb !== 6'h00 || active_out !== 1'b0) begin
            $display("FAIL midframe_refill: rgb=%h act=%b expected 00 and 0", rgb, active_out);
            fails++;
        end
        x = 11'h7C0;
        step();
        tests++;
        if (rgb !== 6'h11 || active_out !== 1'b1) begin
            $display("FAIL midframe_resume: rgb=%h act=%b expected 11 and 1", rgb, active_out);
            fails++;
        end
        step();
        tests++;
        if (rgb !== 6'h39) begin
            $display("FAIL bars_negative_x: rgb=%h expected 39", rgb);
            fails++;
        end
    endtask

    task automatic test_border();
        logic [10:0] bx[3];
        logic [9:0]  by[3];
        logic [5:0]  be[3];
        idle_inputs();
        vsync_pulse(2'd1);
        bx = '{11'd639, 11'd0, 11'd64};
        by = '{10'd100, 10'd64, 10'd479};
`ifdef PIXEL_GEN_BORDER_EN
        be = '{6'h3F, 6'h3F, 6'h3F};
`else
        be = '{6'h00, 6'h00, 6'h00};
`endif
        active_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = bx[i];
            y = by[i];
            step();
            step();
            tests++;
            if (rgb !== be[i]) begin
                $display("FAIL border_%0d_%0d: rgb=%h expected %h", bx[i], by[i], rgb, be[i]);
                fails++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_checker();
        test_blank_hsync();
        test_frame_count();
        test_mode_latch();
        test_back_to_back();
        test_reset_midframe();
        test_border();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
